// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Instruction-fetch controller placed directly upstream of the 16-bit PC
// register. It drives the register's D/enable, reads back its Q, issues
// instruction reads at the current PC, captures the returned word into ir and
// offers it to decode over a valid/ready handshake. Execute may redirect the
// PC (branch/JMP/TRAP). A fetch that waits too long for memory parks the
// block in a sticky FAULT state.
//
// All state changes happen on the FALLING edge of clk, the same edge on which
// the external PC register samples pc_d/pc_ld.
//
// Ports
//   clk             system clock (state updates on negedge)
//   reset           asynchronous, active-low reset
//   pc_q      [15:0] current PC from the PC register's Q
//   pc_d      [15:0] next PC to the PC register's D (combinational)
//   pc_ld           PC register enable (combinational, 0 while in reset)
//   redirect_valid  execute requests a PC redirect this cycle
//   redirect_addr [15:0] redirect target
//   mem_req         instruction read request (registered)
//   mem_addr  [15:0] read address, always pc_q
//   mem_ready       memory returns data this cycle
//   mem_rdata [15:0] returned instruction word
//   ir        [15:0] captured instruction (registered)
//   ir_valid        ir holds an instruction for decode (registered)
//   ir_ready        decode accepts ir
//   halt            level request to stop fetching, sampled on the HOLD handshake
//   fault           sticky fetch-timeout flag (registered)
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
   parameter logic [15:0] RESET_VECTOR = 16'h3000,
   parameter int unsigned MAX_WAIT     = 8   // legal range 2..255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc_q,
   output logic [15:0] pc_d,
   output logic        pc_ld,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_addr,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic [15:0] ir,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        halt,
   output logic        fault
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_FETCH,
      S_HOLD,
      S_HALTED,
      S_FAULT
   } state_e;

   // Counter value seen on the last FETCH cycle allowed to go without ready.
   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic [15:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        fault_q, fault_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        pc_ld_raw;
   logic        redirect_live;

   // Redirects only act while a fetch is in progress or being offered.
   assign redirect_live = redirect_valid &&
                          (state_q inside {S_REQ, S_FETCH, S_HOLD});

   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // through the case statement can leave it unassigned (no latches).
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      fault_d    = fault_q;
      wait_cnt_d = wait_cnt_q;
      pc_d       = pc_q;
      pc_ld_raw  = 1'b0;

      if (redirect_live) begin
         // Redirect beats everything, including same-cycle fetch data, which
         // is dropped so ir keeps its previous contents.
         pc_d       = redirect_addr;
         pc_ld_raw  = 1'b1;
         mem_req_d  = 1'b0;
         ir_valid_d = 1'b0;
         state_d    = S_REQ;
      end else begin
         case (state_q)
            S_BOOT: begin
               pc_d      = RESET_VECTOR;
               pc_ld_raw = 1'b1;
               state_d   = S_REQ;
            end
            S_REQ: begin
               // One-cycle bubble: lets the freshly loaded PC settle on
               // mem_addr before the request goes out.
               mem_req_d  = 1'b1;
               wait_cnt_d = 8'd0;
               state_d    = S_FETCH;
            end
            S_FETCH: begin
               if (mem_ready) begin
                  ir_d       = mem_rdata;
                  ir_valid_d = 1'b1;
                  mem_req_d  = 1'b0;
                  pc_d       = pc_q + 16'd1;   // wraps FFFF -> 0000
                  pc_ld_raw  = 1'b1;
                  state_d    = S_HOLD;
               end else if (wait_cnt_q == LAST_WAIT) begin
                  fault_d   = 1'b1;
                  mem_req_d = 1'b0;
                  state_d   = S_FAULT;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end
            S_HOLD: begin
               if (ir_ready) begin
                  ir_valid_d = 1'b0;
                  state_d    = halt ? S_HALTED : S_REQ;
               end
            end
            S_HALTED: begin
               mem_req_d  = 1'b0;
               ir_valid_d = 1'b0;
            end
            S_FAULT: begin
               mem_req_d  = 1'b0;
               ir_valid_d = 1'b0;
               fault_d    = 1'b1;
            end
            default: state_d = S_BOOT;
         endcase
      end
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_BOOT;
         mem_req_q  <= 1'b0;
         // NOTE: ir is a datapath register but is cleared on reset anyway so
         // decode never sees stale contents from before the reset.
         ir_q       <= 16'h0000;
         ir_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         wait_cnt_q <= 8'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge value of its neighbours.
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         fault_q    <= fault_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // While reset is held the state register sits in BOOT, so pc_d already
   // shows RESET_VECTOR; only the enable has to be suppressed.
   assign pc_ld    = pc_ld_raw & reset;
   assign mem_req  = mem_req_q;
   assign mem_addr = pc_q;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign fault    = fault_q;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Instruction-fetch controller that sits directly upstream of the 16-bit PC register. It drives the register's D and enable inputs and reads back its Q. It issues memory read requests at the current PC, captures the returned word as the instruction, and hands it to decode over a valid/ready handshake. It also applies PC redirects (branch, JMP, TRAP targets) from execute, and detects memory timeouts.

Parameters:
RESET_VECTOR, 16'h3000, PC value loaded in the first cycle after reset.
MAX_WAIT, 8, fetch cycles without mem_ready before FAULT (legal range 2..255).

Ports:
clk  in  1  system clock; all state updates on the falling edge, the same edge on which the PC register samples.
reset  in  1  asynchronous, active-low reset.
pc_q  in  16  current PC, from the PC register's Q.
pc_d  out  16  next PC value, to the PC register's D (combinational).
pc_ld  out  1  PC register enable (combinational).
redirect_valid  in  1  execute requests a PC redirect this cycle.
redirect_addr  in  16  redirect target.
mem_req  out  1  instruction read request (registered).
mem_addr  out  16  read address; equals pc_q.
mem_ready  in  1  memory returns data this cycle.
mem_rdata  in  16  instruction word.
ir  out  16  captured instruction (registered).
ir_valid  out  1  ir holds an instruction for decode (registered).
ir_ready  in  1  decode accepts ir.
halt  in  1  level request to stop fetching.
fault  out  1  sticky fetch-timeout flag (registered).

Behaviour:
- States: BOOT, REQ, FETCH, HOLD, HALTED, FAULT. Encoding is free.
- Reset (reset=0, asynchronous) forces:
  - state=BOOT, mem_req=0, ir=16'h0000, ir_valid=0, fault=0, wait counter=0.
  - pc_ld is forced to 0 while reset=0; pc_d=RESET_VECTOR.
- BOOT: pc_d=RESET_VECTOR, pc_ld=1. On the next edge go to REQ.
- REQ: mem_req<=1 on exit, counter<=0, go to FETCH. This is a one-cycle bubble.
- FETCH: mem_req=1.
  - mem_ready=1: ir<=mem_rdata, ir_valid<=1, mem_req<=0, and pc_d=pc_q+1 with pc_ld=1. Go to HOLD. Increment is modulo 2^16, so FFFF becomes 0000.
  - No ready: counter increments. When the counter reaches MAX_WAIT-1 with no ready, go to FAULT (fault<=1, mem_req<=0).
  - Fetch latency from entering REQ to ir_valid high is 2 edges minimum.
- HOLD: ir_valid=1, ir stable, pc_ld=0.
  - ir_ready=1 and halt=0: ir_valid<=0, go to REQ.
  - ir_ready=1 and halt=1: ir_valid<=0, go to HALTED.
  - ir_ready=0: stay.
- Redirect (redirect_valid=1) in REQ, FETCH or HOLD has highest priority:
  - pc_d=redirect_addr, pc_ld=1. mem_req<=0, ir_valid<=0, go to REQ.
  - In FETCH, any same-cycle mem_ready data is discarded and ir is left unchanged.
  - Ignored in BOOT, HALTED and FAULT.
- halt is sampled only on the HOLD handshake edge. It is ignored in FETCH and REQ so an in-flight fetch completes first.
- HALTED and FAULT are terminal until reset: mem_req=0, pc_ld=0, ir_valid=0. fault stays 1 in FAULT.
- mem_addr is always pc_q. Memory must treat a request as existing only while mem_req=1; dropping mem_req cancels it.
- Reset asserted mid-fetch clears immediately; no handshake is completed.

Test Plan:
- Reset release, mem_ready tied 1, ir_ready tied 1, mem_rdata=16'h1234 → pc_ld=1 in BOOT with pc_d=3000; first ir=1234 with ir_valid; pc_q sequence 3000, 3001, 3002, each 3 cycles apart.
- mem_ready delayed 3 cycles at pc_q=3005 → mem_req held high 4 cycles, mem_addr=3005, then ir captured and pc_d=3006.
- redirect_valid with redirect_addr=4000 in the same cycle as mem_ready in FETCH → ir unchanged, ir_valid=0, PC becomes 4000, next mem_addr=4000.
- ir_ready=0 for 5 cycles in HOLD → ir and ir_valid stable, no new mem_req; then ir_ready=1 with halt=1 → HALTED, mem_req stays 0 for 20 cycles.
- mem_ready never asserted, MAX_WAIT=8 → fault=1 after 8 FETCH cycles, mem_req=0; fault cleared only by reset=0.
- pc_q=FFFF fetch completes → pc_d=0000, pc_ld=1. Then assert reset mid-FETCH → all registered outputs at reset values immediately.
